// File: rtl/nios_system_cpu_div_cell.sv
// nios_system_cpu_div_cell: iterative radix-2 restoring divider for the
// Nios II M-stage. It returns quotient and remainder 35 cycles after an
// accepted start, with a one-cycle done pulse.
//
// Optional feature macro: NIOS_SYSTEM_CPU_DIV_SIGNED_EN
//   defined   -> M_div_signed selects two's-complement (truncating) division
//   undefined -> all operations are unsigned; the FIX state only passes results through
//
// Handshake: a start is accepted only in IDLE or DONE, and only when reset is low.
// M_div_busy is high for the 34 cycles PREP..FIX. M_div_done pulses high for the
// one DONE cycle. Quotient and remainder hold their values until a later FIX
// overwrites them. There is no queuing; a start in any other state is dropped.
module nios_system_cpu_div_cell #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 M_div_start,
  input  logic [DIV_WIDTH-1:0] M_div_src1,
  input  logic [DIV_WIDTH-1:0] M_div_src2,
  input  logic                 M_div_signed,
  output logic                 M_div_busy,
  output logic                 M_div_done,
  output logic [DIV_WIDTH-1:0] M_div_quotient,
  output logic [DIV_WIDTH-1:0] M_div_remainder,
  output logic [2:0]           dbg_state
);

  localparam int W = DIV_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   src1_q, src1_d;     // latched dividend, kept for the divide-by-zero result
  logic [W-1:0]   src2_q, src2_d;     // latched divisor
  logic [W-1:0]   dvd_q, dvd_d;       // dividend magnitude, shifts out MSB first; quotient bits shift in
  logic [W-1:0]   dvs_q, dvs_d;       // divisor magnitude
  logic [W-1:0]   rem_q, rem_d;       // partial remainder (always < divisor, so W bits hold it)
  logic [5:0]     cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   remo_q, remo_d;

  // The 33-bit working remainder exists only between the shift and the trial subtract
  logic [W:0]     rem_sh;
  logic [W:0]     trial;
  logic [W-1:0]   mag1, mag2;
  logic [W-1:0]   fix_q, fix_r;

`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
  logic           signed_q, signed_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
`else
  logic           unused_signed;
  assign unused_signed = M_div_signed;
`endif

  // State and datapath registers, with synchronous reset that takes priority over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
`endif
    end
  end

  // Operand magnitudes and sign correction; plain pass-through when signed support is not built
  always_comb begin
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
    mag1  = (signed_q && src1_q[W-1]) ? (~src1_q + 1'b1) : src1_q;
    mag2  = (signed_q && src2_q[W-1]) ? (~src2_q + 1'b1) : src2_q;
    fix_q = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    fix_r = r_neg_q ? (~rem_q + 1'b1) : rem_q;
`else
    mag1  = src1_q;
    mag2  = src2_q;
    fix_q = dvd_q;
    fix_r = rem_q;
`endif
  end

  // Next-state and datapath update for IDLE/PREP/ITER/FIX/DONE
  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    rem_sh  = {rem_q, dvd_q[W-1]};
    trial   = rem_sh - {1'b0, dvs_q};
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (M_div_start) begin
          src1_d  = M_div_src1;
          src2_d  = M_div_src2;
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
          signed_d = M_div_signed;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
        dvd_d = mag1;
        dvs_d = mag2;
        rem_d = '0;
        cnt_d = '0;
        dz_d  = (src2_q == '0);
`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
        q_neg_d = signed_q & (src1_q[W-1] ^ src2_q[W-1]);
        r_neg_d = signed_q & src1_q[W-1];
`endif
        state_d = ITER;
      end
      ITER: begin
        // A non-negative trial means the divisor fits: keep the difference and shift in a 1
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = src1_q;
        end else begin
          quot_d = fix_q;
          remo_d = fix_r;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; results come straight from their registers
  always_comb begin
    M_div_busy      = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    M_div_done      = (state_q == DONE);
    M_div_quotient  = quot_q;
    M_div_remainder = remo_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_nios_system_cpu_div_cell.sv
// Testbench for nios_system_cpu_div_cell: directed vectors go through a
// scoreboard queue, and a monitor checks results, latency and busy length
// on every done pulse.
module tb_nios_system_cpu_div_cell;

`ifdef NIOS_SYSTEM_CPU_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        M_div_start;
  logic [31:0] M_div_src1;
  logic [31:0] M_div_src2;
  logic        M_div_signed;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quotient;
  logic [31:0] M_div_remainder;
  logic [2:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;

  nios_system_cpu_div_cell #(.DIV_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .M_div_start     (M_div_start),
    .M_div_src1      (M_div_src1),
    .M_div_src2      (M_div_src2),
    .M_div_signed    (M_div_signed),
    .M_div_busy      (M_div_busy),
    .M_div_done      (M_div_done),
    .M_div_quotient  (M_div_quotient),
    .M_div_remainder (M_div_remainder),
    .dbg_state       (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops on every done pulse and checks result, latency, busy length
  always @(negedge clk) begin
    logic [63:0] e;
    int          ec;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (M_div_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check32("quotient", M_div_quotient, e[63:32]);
          check32("remainder", M_div_remainder, e[31:0]);
          check32("done_cycle", cyc, ec);
          check32("busy_cycles", busy_cnt, 34);
        end
        busy_cnt = 0;
      end
      if (M_div_busy) busy_cnt = busy_cnt + 1;
    end
  end

  // Driver: present one start for a single cycle; optionally push its expected result
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input bit push);
    M_div_src1   = a;
    M_div_src2   = b;
    M_div_signed = s;
    M_div_start  = 1'b1;
    if (push) begin
      exp_q.push_back({eq, er});
      exp_cyc_q.push_back(cyc + 35);
    end
    @(posedge clk);
    #1;
    M_div_start  = 1'b0;
    M_div_src1   = $urandom;
    M_div_src2   = $urandom;
    M_div_signed = 1'($urandom_range(0, 1));
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    reset        = 1'b1;
    M_div_start  = 1'b0;
    M_div_src1   = '0;
    M_div_src2   = '0;
    M_div_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_busy", 32'(M_div_busy), 0);
    check32("reset_done", 32'(M_div_done), 0);
    check32("reset_quotient", M_div_quotient, 0);
    check32("reset_remainder", M_div_remainder, 0);
    check32("reset_state", 32'(dbg_state), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    drain();
    issue(32'hFFFFFFF9, 32'd2, 1'b1,
          SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC,
          SIGNED_EN ? 32'hFFFFFFFF : 32'h00000001, 1'b1);
    drain();
    issue(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'h1, 1'b1);
    drain();
    issue(32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    drain();
    issue(32'h80000005, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h80000005, 1'b1);
    drain();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1,
          SIGNED_EN ? 32'h80000000 : 32'h0,
          SIGNED_EN ? 32'h0 : 32'h80000000, 1'b1);
    drain();
    issue(32'd7, 32'hFFFFFFFE, 1'b1,
          SIGNED_EN ? 32'hFFFFFFFD : 32'h0,
          SIGNED_EN ? 32'h1 : 32'h7, 1'b1);
    drain();
    issue(32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1,
          SIGNED_EN ? 32'h2 : 32'h0,
          SIGNED_EN ? 32'hFFFFFFFE : 32'hFFFFFFF8, 1'b1);
    drain();
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    drain();
    issue(32'd5, 32'd10, 1'b0, 32'h0, 32'd5, 1'b1);
    drain();
    issue(32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b1);
    drain();

    // Start reasserted in cycle 10 is ignored
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    issue(32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Start in the DONE cycle is accepted back-to-back
    issue(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 1'b1);
    repeat (34) @(posedge clk);
    #1;
    check32("b2b_in_done", 32'(dbg_state), 4);
    issue(32'h0000FFFF, 32'h100, 1'b0, 32'hFF, 32'hFF, 1'b1);
    drain();

    // Reset pulsed in cycle 20 aborts with no done pulse
    issue(32'd777, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check32("abort_state", 32'(dbg_state), 0);
    check32("abort_busy", 32'(M_div_busy), 0);
    check32("abort_quotient", M_div_quotient, 0);
    check32("abort_remainder", M_div_remainder, 0);
    repeat (40) @(posedge clk);
    #1;
    issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b1);
    drain();

    // Reset and start together: reset wins
    reset       = 1'b1;
    M_div_start = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    M_div_start = 1'b0;
    check32("reset_start_state", 32'(dbg_state), 0);
    check32("reset_start_busy", 32'(M_div_busy), 0);
    repeat (40) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
